lpr_status_collector: RTL and testbench
=======================================

// Module: lpr_status_collector
// PURPOSE
//  Tracks the plate-recognition pipeline phase and event history; packs them into one 32-bit
//  status word that drives the status PIO in_port, which the HPS reads at PIO address 0.
//  HPS acknowledges and clears sticky flags by toggling ack_toggle, driven by a PIO output.
//  All logic is clk-domain; every event input is a 1-cycle pulse, synchronous to clk.
// PARAMETERS
//  TIMEOUT_CYCLES  50_000_000  max cycles allowed in PROCESS before a timeout error (>=2)
//  TO_W            26          timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   synchronous active-low reset
//  frame_start    in   1   pulse: capture of a new frame begins
//  frame_end      in   1   pulse: frame fully captured, OCR starts
//  ocr_done       in   1   pulse: OCR finished for the current frame
//  plate_found    in   1   qualifies ocr_done: 1 = a plate string was produced
//  pipe_err       in   1   pulse: any pipeline fault (FIFO overflow, DMA error)
//  ack_toggle     in   1   HPS acknowledge; any level change = one acknowledge
//  status_word    out  32  packed status, routed to the status PIO in_port
// BEHAVIOUR
//  - Status word: [2:0] state, [3] busy = CAPTURE|PROCESS, [4] result_valid sticky,
//    [5] overrun sticky, [6] error sticky, [7] ack echo = last sampled ack_toggle,
//    [15:8] plate_cnt (wraps mod 256), [23:16] err_cnt (saturates at 255),
//    [31:24] frame_cnt (wraps mod 256).
//  - status_word is a plain concatenation of registers. An event pulse in cycle N appears in
//    status_word after edge N+1. There is no combinational path from any input.
//  - Reset (reset_n=0 at a clk edge): state=IDLE, all stickies/counters/timeout=0.
//    The ack echo and ack_prev take the current ack_toggle value, so no spurious ack occurs.
//    status_word = {24'h0, ack_toggle, 7'h0}. Reset mid-frame discards all progress.
//  - States (encoding 0..4): IDLE, CAPTURE, PROCESS, DONE, ERROR.
//    IDLE/DONE --frame_start--> CAPTURE.
//    CAPTURE --frame_end--> PROCESS; frame_cnt+1; timeout counter cleared.
//    CAPTURE + frame_start --> stay in CAPTURE; set overrun.
//    PROCESS --ocr_done--> DONE; if plate_found, plate_cnt+1 and result_valid=1.
//    PROCESS + frame_start --> ignored; set overrun.
//    PROCESS with timeout reaching TIMEOUT_CYCLES-1 and no ocr_done --> ERROR.
//    pipe_err in CAPTURE/PROCESS/DONE --> ERROR. pipe_err in IDLE sets error only.
//    ERROR leaves only on an acknowledge --> IDLE. Events in ERROR are ignored except pipe_err.
//  - Entering ERROR, or pipe_err in any state: error=1, err_cnt+1 (saturating).
//    This applies once per cycle even if timeout and pipe_err coincide.
//  - Events in IDLE other than frame_start/pipe_err are ignored (no counter change).
//  - Same-cycle priority in PROCESS: pipe_err > ocr_done > timeout. In CAPTURE: pipe_err > frame_end > frame_start.
//  - Acknowledge = ack_toggle != ack_prev. On acknowledge: clear result_valid, overrun, error.
//    Update the echo. ERROR-->IDLE. Counters are never cleared except by reset.
//  - Set vs clear in the same cycle: a set from an event in that cycle wins.
//    The flag reads 1 afterwards.
//  - Timeout counter runs only in PROCESS; it is held at 0 in every other state.
// STRUCTURE
//  - lpr_status_pkg: state enum (3-bit), status-word field bit positions, counter widths.
//  - One sub-module: lpr_event_counter with params W and SATURATE. It is instantiated three
//    times: plate and frame counters wrap (SATURATE=0); the error counter saturates (SATURATE=1).
//  - FSM, stickies, ack edge detect and timeout live in the top module.
// TESTING (TIMEOUT_CYCLES=16 in bench)
//  1 Reset with ack_toggle=1 -> status_word=32'h0000_0080; the next cycle shows no acknowledge effect.
//  2 frame_start, frame_end, then ocr_done+plate_found -> state=DONE.
//    status_word=32'h0100_0113; repeat 256 frames -> frame/plate counts wrap to 0.
//  3 frame_end then no ocr_done for 16 cycles -> state=ERROR, [6]=1, err_cnt=1.
//    Toggle ack -> IDLE, [6]=0, [7] flips, err_cnt stays 1.
//  4 frame_start twice in CAPTURE -> [5]=1, still CAPTURE.
//    Then ack toggled in the same cycle as a third frame_start -> [5] remains 1.
//  5 In PROCESS, pipe_err and ocr_done pulse together -> ERROR.
//    plate_cnt unchanged, err_cnt+1; 300 pipe_err pulses -> err_cnt holds 8'hFF.
//  6 reset_n low for 1 cycle while in PROCESS with counts nonzero -> all fields 0, state IDLE.
//    The timeout counter does not resume.

Source files
------------

// File: rtl/lpr_status_pkg.sv
// Shared types and status-word layout for the plate-recognition status collector.
package lpr_status_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_PROCESS = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } lpr_state_e;

  localparam int CNT_W       = 8;
  localparam int BIT_BUSY    = 3;
  localparam int BIT_RESULT  = 4;
  localparam int BIT_OVERRUN = 5;
  localparam int BIT_ERROR   = 6;
  localparam int BIT_ACK     = 7;
  localparam int LSB_PLATE   = 8;
  localparam int LSB_ERRCNT  = 16;
  localparam int LSB_FRAME   = 24;

endpackage

// File: rtl/lpr_status_if.sv
// Pipeline event pulses, HPS acknowledge and the packed status word seen by the PIO.
interface lpr_status_if;
  logic        frame_start;
  logic        frame_end;
  logic        ocr_done;
  logic        plate_found;
  logic        pipe_err;
  logic        ack_toggle;
  logic [31:0] status_word;

  modport master (
    output frame_start, frame_end, ocr_done, plate_found, pipe_err, ack_toggle,
    input  status_word
  );

  modport slave (
    input  frame_start, frame_end, ocr_done, plate_found, pipe_err, ack_toggle,
    output status_word
  );
endinterface

// File: rtl/lpr_event_counter.sv
// Event counter that either wraps or saturates at all-ones; cleared only by reset.
module lpr_event_counter #(
  parameter int W        = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(SATURATE && (cnt_q == {W{1'b1}})))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/lpr_status_collector.sv
// Pipeline phase FSM, sticky flags, ack edge detect and PROCESS timeout, packed into one word.
// states: IDLE waiting | CAPTURE frame in | PROCESS OCR running | DONE result ready | ERROR wait for ack
module lpr_status_collector
  import lpr_status_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TO_W           = 26
) (
  input logic         clk,
  input logic         reset_n,
  lpr_status_if.slave sif
);

  lpr_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             result_q, result_d;
  logic             overrun_q, overrun_d;
  logic             error_q, error_d;
  logic             ack_prev_q;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic             ack, set_result, set_overrun, err_evt, frame_inc, plate_inc;
  logic [CNT_W-1:0] plate_cnt, err_cnt, frame_cnt;

  assign ack = sif.ack_toggle ^ ack_prev_q;

  always_comb begin
    state_d     = state_q;
    set_result  = 1'b0;
    set_overrun = 1'b0;
    frame_inc   = 1'b0;
    plate_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!sif.pipe_err && sif.frame_start) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (sif.pipe_err) state_d = ST_ERROR;
        else if (sif.frame_end) begin
          state_d   = ST_PROCESS;
          frame_inc = 1'b1;
        end else if (sif.frame_start) set_overrun = 1'b1;
      end
      ST_PROCESS: begin
        set_overrun = sif.frame_start;
        if (sif.pipe_err) state_d = ST_ERROR;
        else if (sif.ocr_done) begin
          state_d    = ST_DONE;
          plate_inc  = sif.plate_found;
          set_result = sif.plate_found;
        end else if (timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) state_d = ST_ERROR;
      end
      ST_DONE: begin
        if (sif.pipe_err) state_d = ST_ERROR;
        else if (sif.frame_start) state_d = ST_CAPTURE;
      end
      ST_ERROR: begin
        if (ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // one error event per cycle, whether from pipe_err, timeout, or both
    err_evt   = sif.pipe_err || (state_d == ST_ERROR && state_q != ST_ERROR);
    busy_d    = (state_d == ST_CAPTURE) || (state_d == ST_PROCESS);
    result_d  = set_result  || (result_q  && !ack);
    overrun_d = set_overrun || (overrun_q && !ack);
    error_d   = err_evt     || (error_q   && !ack);
    timeout_d = (state_q == ST_PROCESS && state_d == ST_PROCESS) ? timeout_q + TO_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      result_q   <= 1'b0;
      overrun_q  <= 1'b0;
      error_q    <= 1'b0;
      ack_prev_q <= sif.ack_toggle;
      timeout_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
      overrun_q  <= overrun_d;
      error_q    <= error_d;
      ack_prev_q <= sif.ack_toggle;
      timeout_q  <= timeout_d;
    end
  end

  lpr_event_counter #(.W(CNT_W), .SATURATE(1'b0)) u_plate_cnt (
    .clk(clk), .reset_n(reset_n), .inc(plate_inc), .cnt(plate_cnt)
  );
  lpr_event_counter #(.W(CNT_W), .SATURATE(1'b1)) u_err_cnt (
    .clk(clk), .reset_n(reset_n), .inc(err_evt), .cnt(err_cnt)
  );
  lpr_event_counter #(.W(CNT_W), .SATURATE(1'b0)) u_frame_cnt (
    .clk(clk), .reset_n(reset_n), .inc(frame_inc), .cnt(frame_cnt)
  );

  always_comb begin
    sif.status_word                         = '0;
    sif.status_word[2:0]                    = state_q;
    sif.status_word[BIT_BUSY]               = busy_q;
    sif.status_word[BIT_RESULT]             = result_q;
    sif.status_word[BIT_OVERRUN]            = overrun_q;
    sif.status_word[BIT_ERROR]              = error_q;
    sif.status_word[BIT_ACK]                = ack_prev_q;
    sif.status_word[LSB_PLATE  +: CNT_W]    = plate_cnt;
    sif.status_word[LSB_ERRCNT +: CNT_W]    = err_cnt;
    sif.status_word[LSB_FRAME  +: CNT_W]    = frame_cnt;
  end

endmodule

// File: tb/tb_lpr_status_collector.sv
// Directed-vector bench for lpr_status_collector with a 16-cycle PROCESS timeout.
module tb_lpr_status_collector;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_bad = 0;

  lpr_status_if sif ();

  lpr_status_collector #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .sif(sif)
  );

  always #5 clk = ~clk;

  task automatic chk_word(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // one clock with the given pulses {frame_start, frame_end, ocr_done, plate_found, pipe_err}
  task automatic cyc(input logic [4:0] ev);
    {sif.frame_start, sif.frame_end, sif.ocr_done, sif.plate_found, sif.pipe_err} = ev;
    @(posedge clk);
    #1;
    {sif.frame_start, sif.frame_end, sif.ocr_done, sif.plate_found, sif.pipe_err} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [4:0] E_FS = 5'b10000;
  localparam logic [4:0] E_FE = 5'b01000;
  localparam logic [4:0] E_OD = 5'b00100;
  localparam logic [4:0] E_PF = 5'b00010;
  localparam logic [4:0] E_PE = 5'b00001;

  initial begin
    {sif.frame_start, sif.frame_end, sif.ocr_done, sif.plate_found, sif.pipe_err} = '0;
    sif.ack_toggle = 1'b1;
    reset_n        = 1'b0;
    @(posedge clk);
    #1;
    chk_word("reset_ack1", sif.status_word, 32'h0000_0080);
    reset_n = 1'b1;
    idle(1);
    chk_word("no_spurious_ack", sif.status_word, 32'h0000_0080);

    reset_n        = 1'b0;
    sif.ack_toggle = 1'b0;
    idle(1);
    reset_n = 1'b1;
    chk_word("reset_ack0", sif.status_word, 32'h0000_0000);
    cyc(E_FS);
    chk_word("capture", sif.status_word, 32'h0000_0009);
    cyc(E_FE);
    chk_word("process", sif.status_word, 32'h0100_000A);
    cyc(E_OD | E_PF);
    chk_word("done_plate", sif.status_word, 32'h0100_0113);
    for (int i = 0; i < 255; i++) begin
      cyc(E_FS);
      cyc(E_FE);
      cyc(E_OD | E_PF);
    end
    chk_word("wrap_256", sif.status_word, 32'h0000_0013);

    cyc(E_FS);
    chk_word("capture_rv", sif.status_word, 32'h0000_0019);
    cyc(E_FE);
    chk_word("process2", sif.status_word, 32'h0100_001A);
    idle(15);
    chk_word("timeout_edge", sif.status_word, 32'h0100_001A);
    idle(1);
    chk_word("timeout_err", sif.status_word, 32'h0101_0054);
    sif.ack_toggle = ~sif.ack_toggle;
    idle(1);
    chk_word("ack_to_idle", sif.status_word, 32'h0101_0080);

    cyc(E_FS);
    chk_word("capture3", sif.status_word, 32'h0101_0089);
    cyc(E_FS);
    chk_word("overrun", sif.status_word, 32'h0101_00A9);
    sif.ack_toggle = ~sif.ack_toggle;
    cyc(E_FS);
    chk_word("set_beats_clear", sif.status_word, 32'h0101_0029);
    sif.ack_toggle = ~sif.ack_toggle;
    idle(1);
    chk_word("ack_clr_ovr", sif.status_word, 32'h0101_0089);

    cyc(E_FE);
    chk_word("process3", sif.status_word, 32'h0201_008A);
    cyc(E_PE | E_OD | E_PF);
    chk_word("err_beats_ocr", sif.status_word, 32'h0202_00C4);
    for (int i = 0; i < 253; i++) cyc(E_PE);
    chk_word("err_sat_reach", sif.status_word, 32'h02FF_00C4);
    for (int i = 0; i < 47; i++) cyc(E_PE);
    chk_word("err_sat_hold", sif.status_word, 32'h02FF_00C4);

    sif.ack_toggle = ~sif.ack_toggle;
    idle(1);
    chk_word("ack_idle2", sif.status_word, 32'h02FF_0000);
    cyc(E_FS);
    cyc(E_FE);
    chk_word("process4", sif.status_word, 32'h03FF_000A);
    idle(5);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    chk_word("mid_reset", sif.status_word, 32'h0000_0000);
    idle(20);
    chk_word("no_resume", sif.status_word, 32'h0000_0000);
    cyc(E_FS);
    cyc(E_FE);
    idle(15);
    chk_word("to_restart", sif.status_word, 32'h0100_000A);
    idle(1);
    chk_word("to_err2", sif.status_word, 32'h0101_0044);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
